// File: rtl/cronometer_controller.sv
// ============================================================================
// Module   : cronometer_controller
// Brief    : Button sequencer and display path for the stopwatch chronometer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cronometer_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], btn};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // One-cycle pulse on the rising edge of the accepted level only.
  assign press = r_level & ~r_level_d;

endmodule

module cronometer_controller #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [5:0] cron_seconds,
  input  logic [5:0] cron_minutes,
  input  logic [7:0] cron_hours,
  output logic       start_stop,
  output logic       cron_clear,
  output logic [5:0] disp_seconds,
  output logic [5:0] disp_minutes,
  output logic [7:0] disp_hours,
  output logic       lap_active,
  output logic [1:0] state
);

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_RUN   = 2'b01;
  localparam logic [1:0] c_PAUSE = 2'b10;
  localparam logic [1:0] c_LAP   = 2'b11;

  logic       w_ss_p;
  logic       w_lr_raw_p;
  logic       w_lr_p;
  logic [1:0] w_state_nxt;
  logic       w_start_stop_nxt;
  logic       w_clear_nxt;
  logic       w_lap_nxt;
  logic       w_snap_load;

  logic [1:0] r_state;
  logic       r_start_stop;
  logic       r_cron_clear;
  logic       r_lap_active;
  logic [5:0] r_snap_seconds;
  logic [5:0] r_snap_minutes;
  logic [7:0] r_snap_hours;
  logic [5:0] r_disp_seconds;
  logic [5:0] r_disp_minutes;
  logic [7:0] r_disp_hours;

  cronometer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .press (w_ss_p)
  );

  cronometer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lr),
    .press (w_lr_raw_p)
  );

  // Start/stop has priority when both presses land in the same cycle.
  assign w_lr_p = w_lr_raw_p & ~w_ss_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_IDLE;
      r_start_stop <= 1'b0;
      r_cron_clear <= 1'b1;
      r_lap_active <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_stop <= w_start_stop_nxt;
      r_cron_clear <= w_clear_nxt;
      r_lap_active <= w_lap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_ss_p) w_state_nxt = c_RUN;
      c_RUN:   if (w_ss_p) w_state_nxt = c_PAUSE;
               else if (w_lr_p) w_state_nxt = c_LAP;
      c_LAP:   if (w_ss_p) w_state_nxt = c_PAUSE;
               else if (w_lr_p) w_state_nxt = c_RUN;
      c_PAUSE: if (w_ss_p) w_state_nxt = c_RUN;
               else if (w_lr_p) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_start_stop_nxt = (w_state_nxt == c_RUN) || (w_state_nxt == c_LAP);
    w_lap_nxt        = (w_state_nxt == c_LAP);
    w_clear_nxt      = w_lr_p && ((r_state == c_IDLE) || (r_state == c_PAUSE));
    w_snap_load      = w_lr_p && (r_state == c_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap_seconds <= '0;
      r_snap_minutes <= '0;
      r_snap_hours   <= '0;
      r_disp_seconds <= '0;
      r_disp_minutes <= '0;
      r_disp_hours   <= '0;
    end else begin
      if (w_snap_load) begin
        r_snap_seconds <= cron_seconds;
        r_snap_minutes <= cron_minutes;
        r_snap_hours   <= cron_hours;
      end
      if (r_state == c_LAP) begin
        r_disp_seconds <= r_snap_seconds;
        r_disp_minutes <= r_snap_minutes;
        r_disp_hours   <= r_snap_hours;
      end else begin
        r_disp_seconds <= cron_seconds;
        r_disp_minutes <= cron_minutes;
        r_disp_hours   <= cron_hours;
      end
    end
  end

  assign state        = r_state;
  assign start_stop   = r_start_stop;
  assign cron_clear   = r_cron_clear;
  assign lap_active   = r_lap_active;
  assign disp_seconds = r_disp_seconds;
  assign disp_minutes = r_disp_minutes;
  assign disp_hours   = r_disp_hours;

endmodule

`default_nettype wire

// File: tb/tb_cronometer_controller.sv
// ============================================================================
// Module   : tb_cronometer_controller
// Brief    : Directed, table-driven bench for cronometer_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cronometer_controller;

  logic       clk;
  logic       reset;
  logic       btn_ss;
  logic       btn_lr;
  logic [5:0] cron_seconds;
  logic [5:0] cron_minutes;
  logic [7:0] cron_hours;
  logic       start_stop;
  logic       cron_clear;
  logic [5:0] disp_seconds;
  logic [5:0] disp_minutes;
  logic [7:0] disp_hours;
  logic       lap_active;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  cronometer_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_ss       (btn_ss),
    .btn_lr       (btn_lr),
    .cron_seconds (cron_seconds),
    .cron_minutes (cron_minutes),
    .cron_hours   (cron_hours),
    .start_stop   (start_stop),
    .cron_clear   (cron_clear),
    .disp_seconds (disp_seconds),
    .disp_minutes (disp_minutes),
    .disp_hours   (disp_hours),
    .lap_active   (lap_active),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       lr;
    logic [5:0] sec;
    logic [5:0] mn;
    logic [7:0] hr;
    logic [1:0] st;
    logic       go;
    logic       lap;
    logic       clr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_btns();
    @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    edges(12);
  endtask

  logic [1:0] prev_state;

  initial begin
    // Walk starts in RUN; snapshot values come from each row's cron inputs.
    vecs[0]  = '{1'b1, 1'b0, 6'd5,  6'd7,  8'd200, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'd6,  6'd8,  8'd201, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6'd7,  6'd9,  8'd202, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 6'd8,  6'd10, 8'd203, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 6'd9,  6'd11, 8'd255, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 6'd10, 6'd12, 8'd0,   2'b01, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 6'd20, 6'd30, 8'd40,  2'b11, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 6'd21, 6'd31, 8'd41,  2'b10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 6'd22, 6'd32, 8'd42,  2'b01, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 6'd23, 6'd33, 8'd43,  2'b11, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 6'd59, 6'd59, 8'd250, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 6'd33, 6'd44, 8'd128, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 6'd1,  6'd2,  8'd3,   2'b01, 1'b1, 1'b0, 1'b0};

    reset        = 1'b0;
    btn_ss       = 1'b0;
    btn_lr       = 1'b0;
    cron_seconds = 6'd0;
    cron_minutes = 6'd0;
    cron_hours   = 8'd0;

    // Reset state and release.
    edges(3);
    check("rst_state", state, 0);
    check("rst_start_stop", start_stop, 0);
    check("rst_cron_clear", cron_clear, 1);
    check("rst_lap_active", lap_active, 0);
    check("rst_disp_seconds", disp_seconds, 0);
    @(negedge clk);
    reset = 1'b1;
    edges(1);
    check("rel_cron_clear", cron_clear, 0);
    check("rel_state", state, 0);

    // Held start/stop: state changes exactly 7 edges after the rise.
    @(negedge clk);
    btn_ss = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      edges(1);
      if (k == 6) check("lat_state_k6", state, 0);
      if (k == 7) begin
        check("lat_state_k7", state, 1);
        check("lat_start_stop_k7", start_stop, 1);
      end
      if (k == 20) check("lat_state_k20", state, 1);
    end
    release_btns();
    check("after_release_state", state, 1);

    // Bounce shorter than the debounce window yields nothing.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      btn_ss = (b % 2 == 0) ? 1'b1 : 1'b0;
      edges(1);
      @(negedge clk);
    end
    btn_ss = 1'b0;
    for (int k = 0; k < 15; k++) begin
      edges(1);
      if (state != 2'b01) check("bounce_state", state, 1);
    end
    check("bounce_state_final", state, 1);

    // Table walk through the state machine.
    prev_state = 2'b01;
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      cron_seconds = vecs[v].sec;
      cron_minutes = vecs[v].mn;
      cron_hours   = vecs[v].hr;
      btn_ss       = vecs[v].ss;
      btn_lr       = vecs[v].lr;
      edges(6);
      check($sformatf("v%0d_state_pre", v), state, prev_state);
      edges(1);
      check($sformatf("v%0d_state", v), state, vecs[v].st);
      check($sformatf("v%0d_start_stop", v), start_stop, vecs[v].go);
      check($sformatf("v%0d_lap_active", v), lap_active, vecs[v].lap);
      check($sformatf("v%0d_cron_clear", v), cron_clear, vecs[v].clr);
      edges(1);
      check($sformatf("v%0d_cron_clear_end", v), cron_clear, 0);
      check($sformatf("v%0d_disp_seconds", v), disp_seconds, vecs[v].sec);
      check($sformatf("v%0d_disp_minutes", v), disp_minutes, vecs[v].mn);
      check($sformatf("v%0d_disp_hours", v), disp_hours, vecs[v].hr);
      prev_state = vecs[v].st;
      release_btns();
    end

    // Lap freeze while the live count advances, then return to live.
    @(negedge clk);
    cron_seconds = 6'd12;
    btn_lr = 1'b1;
    edges(7);
    check("lap_state", state, 3);
    check("lap_active", lap_active, 1);
    @(negedge clk);
    btn_lr = 1'b0;
    for (int s = 13; s <= 15; s++) begin
      @(negedge clk);
      cron_seconds = 6'(s);
      edges(1);
      check($sformatf("lap_hold_%0d", s), disp_seconds, 12);
    end
    edges(12);
    check("lap_hold_settled", disp_seconds, 12);
    @(negedge clk);
    btn_lr = 1'b1;
    edges(7);
    check("unlap_state", state, 1);
    check("unlap_lap_active", lap_active, 0);
    edges(1);
    check("unlap_disp_live", disp_seconds, 15);
    @(negedge clk);
    cron_seconds = 6'd16;
    edges(1);
    check("unlap_disp_track", disp_seconds, 16);
    release_btns();

    // Enter LAP, start a start/stop debounce, reset with the counter at 2.
    @(negedge clk);
    btn_lr = 1'b1;
    edges(7);
    check("pre_rst_state", state, 3);
    release_btns();
    @(negedge clk);
    btn_ss = 1'b1;
    edges(4);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_start_stop", start_stop, 0);
    check("async_rst_cron_clear", cron_clear, 1);
    check("async_rst_lap_active", lap_active, 0);
    check("async_rst_disp_seconds", disp_seconds, 0);
    check("async_rst_disp_minutes", disp_minutes, 0);
    check("async_rst_disp_hours", disp_hours, 0);
    @(negedge clk);
    btn_ss = 1'b0;
    edges(2);
    @(negedge clk);
    reset = 1'b1;
    edges(1);
    check("post_rst_cron_clear", cron_clear, 0);
    edges(10);
    check("post_rst_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
